// File: rtl/step_controller_pkg.sv
// Shared state encoding and default timing for the single-step button controller.
package step_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } step_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    // Width of a counter that must hold values 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/step_controller_sync_debounce.sv
// Two-flop synchronizer plus a run-length counter that flags the cycle in which the
// synchronized level has matched target_level for STABLE_CYCLES consecutive cycles.
module sync_debounce
    import step_controller_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    input  logic target_level,
    output logic level,
    output logic stable_done
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_meta;
    logic [CNT_W-1:0] run_cnt;

    // The counter restarts after a hit so the owner sees one pulse per qualified run.
    assign stable_done = (level == target_level) && (run_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            level     <= 1'b0;
            run_cnt   <= '0;
        end else begin
            sync_meta <= raw_in;
            level     <= sync_meta;
            if ((level != target_level) || stable_done) begin
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_controller.sv
// Single-step controller: debounced push-button to a step_req/step_ack handshake.
// Auto-repeat while the button is held is built only when STEP_AUTOREPEAT_EN is defined.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | button released, waiting for a synchronized 1
// ST_PRESS_DB   | counting consecutive 1 cycles towards an accepted press
// ST_HELD       | press accepted (one step issued), counting towards auto-repeat
// ST_REPEAT     | auto-repeat: one step every REPEAT_PERIOD held cycles
// ST_RELEASE_DB | counting consecutive 0 cycles; a 1 resumes HELD/REPEAT
module step_controller
    import step_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        debug_core,
    input  logic        raw_next_inst,
    input  logic        step_ack,
    output logic        step_req,
    output logic        button_stable,
    output logic [15:0] step_count,
    output logic        overrun
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("step_controller: DEBOUNCE_CYCLES must be at least 1");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
        $error("step_controller: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    step_state_t state;
    logic        level;
    logic        db_done;
    logic        db_target;
    logic        step_evt;

`ifdef STEP_AUTOREPEAT_EN
    localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned        TIMER_W     = cnt_width(TIMER_MAX);
    localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);

    logic [TIMER_W-1:0] rpt_timer;
    logic               ret_repeat;
`endif

    // Press qualification counts 1s; every other state counts 0s towards release.
    assign db_target = (state == ST_IDLE) || (state == ST_PRESS_DB);

    sync_debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_next_inst),
        .target_level(db_target),
        .level       (level),
        .stable_done (db_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            button_stable <= 1'b0;
            step_evt      <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
            rpt_timer     <= '0;
            ret_repeat    <= 1'b0;
`endif
        end else begin
            step_evt <= 1'b0;
            case (state)
                ST_IDLE, ST_PRESS_DB: begin
                    if (!level) begin
                        state <= ST_IDLE;
                    end else if (db_done) begin
                        state         <= ST_HELD;
                        button_stable <= 1'b1;
                        step_evt      <= 1'b1;
`ifdef STEP_AUTOREPEAT_EN
                        rpt_timer     <= DELAY_LOAD;
`endif
                    end else begin
                        state <= ST_PRESS_DB;
                    end
                end
                ST_HELD: begin
                    if (!level) begin
                        state         <= db_done ? ST_IDLE : ST_RELEASE_DB;
                        button_stable <= !db_done;
`ifdef STEP_AUTOREPEAT_EN
                        ret_repeat    <= 1'b0;
`endif
                    end
`ifdef STEP_AUTOREPEAT_EN
                    else if (rpt_timer == '0) begin
                        state     <= ST_REPEAT;
                        rpt_timer <= PERIOD_LOAD;
                    end else begin
                        rpt_timer <= rpt_timer - TIMER_W'(1);
                    end
`endif
                end
`ifdef STEP_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (!level) begin
                        state         <= db_done ? ST_IDLE : ST_RELEASE_DB;
                        button_stable <= !db_done;
                        ret_repeat    <= 1'b1;
                    end else if (rpt_timer == '0) begin
                        step_evt  <= 1'b1;
                        rpt_timer <= PERIOD_LOAD;
                    end else begin
                        rpt_timer <= rpt_timer - TIMER_W'(1);
                    end
                end
`endif
                ST_RELEASE_DB: begin
                    // The repeat timer is left untouched here so a glitch resumes it.
                    if (level) begin
`ifdef STEP_AUTOREPEAT_EN
                        state <= ret_repeat ? ST_REPEAT : ST_HELD;
`else
                        state <= ST_HELD;
`endif
                    end else if (db_done) begin
                        state         <= ST_IDLE;
                        button_stable <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    button_stable <= 1'b0;
                end
            endcase
        end
    end

    // Only one request may be outstanding; an event arriving while it is pending is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_req   <= 1'b0;
            overrun    <= 1'b0;
            step_count <= 16'h0000;
        end else begin
            if (step_req && step_ack) begin
                step_count <= step_count + 16'd1;
            end
            if (!debug_core) begin
                step_req <= 1'b0;
            end else if (step_req) begin
                if (step_ack) begin
                    step_req <= 1'b0;
                end
                if (step_evt) begin
                    overrun <= 1'b1;
                end
            end else if (step_evt) begin
                step_req <= 1'b1;
            end
        end
    end

endmodule
